msrv32_wb_unit: RTL and testbench
=================================

Name: msrv32_wb_unit

Overview:
- Write-back stage. It is the writer side of the msrv32_integer_file port (rd_addr_in / wr_en_in / rd_in).
- Accepts retiring instructions from execute and selects the write-back source: ALU, load, CSR, PC+4 or immediate.
- Aligns and extends load data returned by the data memory.
- Drives one registered write per instruction into the integer file. Stalls the front end while a load response is outstanding.

Parameters:
- LOAD_TIMEOUT, 255: max cycles spent in WAIT_LOAD before abort. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy LOAD_TIMEOUT < 2**TO_W.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  synchronous, active-high reset
- ex_valid_in  in  1  execute presents an instruction
- ex_ready_out  out  1  stage accepts; instruction is taken when ex_valid_in && ex_ready_out
- ex_rd_addr_in  in  5  destination register
- ex_rf_wr_en_in  in  1  instruction writes rd
- ex_wb_sel_in  in  3  0=ALU 1=LOAD 2=CSR 3=PC+4 4=IMM; 5-7 reserved, treated as no write
- ex_alu_result_in  in  32  ALU result; also the load byte address
- ex_csr_data_in  in  32  CSR read data
- ex_pc_plus4_in  in  32  link value
- ex_imm_in  in  32  LUI immediate
- ex_load_size_in  in  2  0=byte 1=half 2=word
- ex_load_unsigned_in  in  1  zero-extend when 1
- dm_rdata_in  in  32  data memory read data
- dm_rvalid_in  in  1  read data valid, one cycle per load
- rd_addr_out  out  5  to integer file rd_addr_in
- wr_en_out  out  1  to integer file wr_en_in
- rd_out  out  32  to integer file rd_in
- stall_out  out  1  equals !ex_ready_out
- load_err_out  out  1  sticky load-timeout flag

Behaviour:
- Reset (rst_in=1 at a clk edge): state=IDLE, wr_en_out=0, rd_addr_out=0, rd_out=0, load_err_out=0, timeout counter=0. Pending load context is discarded.
- States:
  - IDLE: ex_ready_out=1.
  - WAIT_LOAD: ex_ready_out=0.
- IDLE, instruction accepted with wb_sel in 0,2,3,4:
  - Next cycle: wr_en_out = ex_rf_wr_en_in && (ex_rd_addr_in != 0); rd_addr_out = ex_rd_addr_in; rd_out = selected source.
  - Latency is exactly 1 cycle, back-to-back throughput is 1 per cycle, and the state stays IDLE.
- IDLE, instruction accepted with wb_sel=LOAD:
  - Capture rd, size, unsigned flag and addr[1:0] = ex_alu_result_in[1:0].
  - Go to WAIT_LOAD and clear the counter.
  - Next cycle: wr_en_out=0.
- IDLE, no acceptance: next cycle wr_en_out=0. rd_addr_out and rd_out hold their previous values.
- WAIT_LOAD, dm_rvalid_in=1:
  - Extract data, write it the next cycle with the same rd!=0 / wr_en gating, and return to IDLE.
  - ex_ready_out is high again in that next cycle.
- Load extraction:
  - Byte: lane addr[1:0], i.e. bits [8*a+7 : 8*a].
  - Half: lane addr[1] (bits 15:0 or 31:16); addr[0] is ignored.
  - Word: whole word; addr ignored.
  - Sign-extend from the top bit of the lane unless unsigned=1.
  - Size 3 is treated as word.
- WAIT_LOAD, no rvalid:
  - Counter increments each cycle.
  - When LOAD_TIMEOUT != 0 and the counter equals LOAD_TIMEOUT-1 with no rvalid: go to IDLE with no write, and set load_err_out=1.
  - load_err_out is cleared only by reset.
- dm_rvalid_in while IDLE: ignored (stale or late response). No write occurs.
- ex_valid_in while WAIT_LOAD: not accepted. Execute must hold its inputs.
- Reset asserted in WAIT_LOAD: the load is abandoned. A response arriving after reset is ignored per the IDLE rule.
- rd_addr 0: never write. wr_en_out stays 0, though rd_addr_out and rd_out still update.
- Reserved wb_sel (5-7): accepted, no write, state stays IDLE.

Decomposition:
- Shared package msrv32_pkg holds:
  - Write-back select constants WB_ALU, WB_LOAD, WB_CSR, WB_PC4, WB_IMM.
  - Load size constants LS_BYTE, LS_HALF, LS_WORD.
  - State encodings S_IDLE, S_WAIT_LOAD.
- One combinational sub-module, msrv32_load_align: inputs rdata[31:0], addr[1:0], size[1:0], unsigned; output data[31:0]. It can be verified standalone.

Test Plan:
- Reset, then ALU op: rd=5, sel=ALU, alu=32'h12345678. Expect one cycle later wr_en_out=1, rd_addr_out=5, rd_out=32'h12345678. The next idle cycle has wr_en_out=0.
- Signed byte load: rd=7, addr lsb=2'b11, size=byte, signed. Return rdata=32'h80FF_0000 after 3 cycles. Expect stall_out=1 for those cycles, then a write of rd=7 with 32'hFFFF_FF80, then stall_out=0.
- Unsigned half load: addr lsb=2'b10, rdata=32'hBEEF_1234. Expect rd_out=32'h0000_BEEF. Repeat signed: expect 32'hFFFF_BEEF.
- rd=0 guard: ALU op with rd=0, alu=32'hABCDEF01, wr_en=1. Expect wr_en_out=0. Next, PC+4 op to rd=1 with pc_plus4=32'h0000_0104: expect a write of 32'h0000_0104.
- Timeout with LOAD_TIMEOUT=4: issue a load and never send rvalid. Expect return to IDLE after 4 cycles in WAIT_LOAD, no write, load_err_out=1 and held. A later dm_rvalid_in=1 produces no write.
- Reset mid-load: issue a load, assert rst_in for 1 cycle in WAIT_LOAD, then pulse dm_rvalid_in. Expect ex_ready_out=1, wr_en_out=0 throughout, and load_err_out=0.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 write-back stage.
package msrv32_pkg;

    // Write-back source selects
    localparam logic [2:0] WB_ALU  = 3'd0;
    localparam logic [2:0] WB_LOAD = 3'd1;
    localparam logic [2:0] WB_CSR  = 3'd2;
    localparam logic [2:0] WB_PC4  = 3'd3;
    localparam logic [2:0] WB_IMM  = 3'd4;

    // Load access sizes; 2'd3 falls through to word
    localparam logic [1:0] LS_BYTE = 2'd0;
    localparam logic [1:0] LS_HALF = 2'd1;
    localparam logic [1:0] LS_WORD = 2'd2;

    typedef enum logic {
        S_IDLE      = 1'b0,
        S_WAIT_LOAD = 1'b1
    } wb_state_t;

    // True for the non-load selects that produce a register write
    function automatic logic wb_sel_writes(input logic [2:0] sel);
        return (sel == WB_ALU) || (sel == WB_CSR) || (sel == WB_PC4) || (sel == WB_IMM);
    endfunction

    // Immediate (non-load) write-back value; reserved selects yield zero
    function automatic logic [31:0] wb_source(input logic [2:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] csr,
                                              input logic [31:0] pc4,
                                              input logic [31:0] imm);
        case (sel)
            WB_ALU:  return alu;
            WB_CSR:  return csr;
            WB_PC4:  return pc4;
            WB_IMM:  return imm;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/msrv32_wb_unit_if.sv
// Execute -> write-back instruction bus with valid/ready handshake.
interface msrv32_wb_unit_if;
    logic        ex_valid_in;
    logic        ex_ready_out;
    logic [4:0]  ex_rd_addr_in;
    logic        ex_rf_wr_en_in;
    logic [2:0]  ex_wb_sel_in;
    logic [31:0] ex_alu_result_in;
    logic [31:0] ex_csr_data_in;
    logic [31:0] ex_pc_plus4_in;
    logic [31:0] ex_imm_in;
    logic [1:0]  ex_load_size_in;
    logic        ex_load_unsigned_in;

    modport master (
        output ex_valid_in, ex_rd_addr_in, ex_rf_wr_en_in, ex_wb_sel_in,
               ex_alu_result_in, ex_csr_data_in, ex_pc_plus4_in, ex_imm_in,
               ex_load_size_in, ex_load_unsigned_in,
        input  ex_ready_out
    );

    modport slave (
        input  ex_valid_in, ex_rd_addr_in, ex_rf_wr_en_in, ex_wb_sel_in,
               ex_alu_result_in, ex_csr_data_in, ex_pc_plus4_in, ex_imm_in,
               ex_load_size_in, ex_load_unsigned_in,
        output ex_ready_out
    );
endinterface

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half lane of a load word and extends it to 32 bits.
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane pick and sign/zero extension
    always_comb begin
        shifted   = rdata >> {addr, 3'b000};
        byte_lane = shifted[7:0];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            LS_BYTE: data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
            LS_HALF: data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/msrv32_wb_unit.sv
// Write-back stage: selects the result source, aligns load data and issues one
// registered integer-file write per instruction; stalls execute during loads.
//
//   state       | meaning
//   S_IDLE      | ready for a new instruction from execute
//   S_WAIT_LOAD | load issued, waiting for dm_rvalid_in or timeout
module msrv32_wb_unit
    import msrv32_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 255,
    parameter int TO_W         = 8
)(
    input  logic                clk_in,
    input  logic                rst_in,
    msrv32_wb_unit_if.slave     ex,
    input  logic [31:0]         dm_rdata_in,
    input  logic                dm_rvalid_in,
    output logic [4:0]          rd_addr_out,
    output logic                wr_en_out,
    output logic [31:0]         rd_out,
    output logic                stall_out,
    output logic                load_err_out
);

    localparam bit             TO_ENABLE = (LOAD_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'((LOAD_TIMEOUT == 0) ? 0 : LOAD_TIMEOUT - 1);

    wb_state_t       state, state_nxt;
    logic            ready;
    logic            take_load;
    logic            timeout_hit;
    logic [TO_W-1:0] to_cnt;

    logic [4:0]      ld_rd;
    logic            ld_wr_en;
    logic [1:0]      ld_size;
    logic            ld_unsigned;
    logic [1:0]      ld_addr;
    logic [31:0]     ld_data;

    logic            wr_en_nxt;
    logic [4:0]      rd_addr_nxt;
    logic [31:0]     rd_nxt;

    msrv32_load_align u_align (
        .rdata       (dm_rdata_in),
        .addr        (ld_addr),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .data        (ld_data)
    );

    assign take_load   = (state == S_IDLE) && ex.ex_valid_in && (ex.ex_wb_sel_in == WB_LOAD);
    assign timeout_hit = TO_ENABLE && (state == S_WAIT_LOAD) && !dm_rvalid_in && (to_cnt == TO_LAST);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a response always wins over a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (take_load) state_nxt = S_WAIT_LOAD;
            S_WAIT_LOAD: if (dm_rvalid_in || timeout_hit) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Handshake and next-cycle write values
    always_comb begin
        ready       = (state == S_IDLE);
        wr_en_nxt   = 1'b0;
        rd_addr_nxt = rd_addr_out;
        rd_nxt      = rd_out;
        case (state)
            S_IDLE: begin
                if (ex.ex_valid_in && (ex.ex_wb_sel_in != WB_LOAD)) begin
                    rd_addr_nxt = ex.ex_rd_addr_in;
                    rd_nxt      = wb_source(ex.ex_wb_sel_in, ex.ex_alu_result_in,
                                            ex.ex_csr_data_in, ex.ex_pc_plus4_in, ex.ex_imm_in);
                    wr_en_nxt   = ex.ex_rf_wr_en_in && (ex.ex_rd_addr_in != 5'd0) &&
                                  wb_sel_writes(ex.ex_wb_sel_in);
                end
            end
            S_WAIT_LOAD: begin
                if (dm_rvalid_in) begin
                    rd_addr_nxt = ld_rd;
                    rd_nxt      = ld_data;
                    wr_en_nxt   = ld_wr_en && (ld_rd != 5'd0);
                end
            end
            default: ;
        endcase
    end

    assign ex.ex_ready_out = ready;
    assign stall_out       = !ready;

    // Write port registers, load context, timeout counter and sticky error
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en_out    <= 1'b0;
            rd_addr_out  <= 5'd0;
            rd_out       <= 32'h0;
            load_err_out <= 1'b0;
            to_cnt       <= '0;
            ld_rd        <= 5'd0;
            ld_wr_en     <= 1'b0;
            ld_size      <= 2'd0;
            ld_unsigned  <= 1'b0;
            ld_addr      <= 2'd0;
        end else begin
            wr_en_out   <= wr_en_nxt;
            rd_addr_out <= rd_addr_nxt;
            rd_out      <= rd_nxt;
            if (take_load) begin
                ld_rd       <= ex.ex_rd_addr_in;
                ld_wr_en    <= ex.ex_rf_wr_en_in;
                ld_size     <= ex.ex_load_size_in;
                ld_unsigned <= ex.ex_load_unsigned_in;
                ld_addr     <= ex.ex_alu_result_in[1:0];
                to_cnt      <= '0;
            end else if (state == S_WAIT_LOAD) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (timeout_hit) load_err_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_msrv32_wb_unit.sv
// Directed bench for msrv32_wb_unit (built with LOAD_TIMEOUT=4).
module tb_msrv32_wb_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic [31:0] rd_data;
    logic        stall;
    logic        load_err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    msrv32_wb_unit_if ex_bus();

    msrv32_wb_unit #(.LOAD_TIMEOUT(4), .TO_W(8)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .ex           (ex_bus),
        .dm_rdata_in  (dm_rdata),
        .dm_rvalid_in (dm_rvalid),
        .rd_addr_out  (rd_addr),
        .wr_en_out    (wr_en),
        .rd_out       (rd_data),
        .stall_out    (stall),
        .load_err_out (load_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_bus.ex_valid_in         = 1'b0;
        ex_bus.ex_rd_addr_in       = 5'd0;
        ex_bus.ex_rf_wr_en_in      = 1'b0;
        ex_bus.ex_wb_sel_in        = 3'd0;
        ex_bus.ex_alu_result_in    = 32'h0;
        ex_bus.ex_csr_data_in      = 32'h0;
        ex_bus.ex_pc_plus4_in      = 32'h0;
        ex_bus.ex_imm_in           = 32'h0;
        ex_bus.ex_load_size_in     = 2'd0;
        ex_bus.ex_load_unsigned_in = 1'b0;
    endtask

    task automatic drive_op(input logic [4:0] rd, input logic [2:0] sel, input logic we,
                            input logic [31:0] val);
        clear_ex();
        ex_bus.ex_valid_in      = 1'b1;
        ex_bus.ex_rd_addr_in    = rd;
        ex_bus.ex_rf_wr_en_in   = we;
        ex_bus.ex_wb_sel_in     = sel;
        ex_bus.ex_alu_result_in = (sel == 3'd0) ? val : 32'h5555_5555;
        ex_bus.ex_csr_data_in   = (sel == 3'd2) ? val : 32'h6666_6666;
        ex_bus.ex_pc_plus4_in   = (sel == 3'd3) ? val : 32'h7777_7777;
        ex_bus.ex_imm_in        = (sel == 3'd4) ? val : 32'h8888_8888;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] addr,
                              input logic [1:0] size, input logic uns);
        clear_ex();
        ex_bus.ex_valid_in         = 1'b1;
        ex_bus.ex_rd_addr_in       = rd;
        ex_bus.ex_rf_wr_en_in      = 1'b1;
        ex_bus.ex_wb_sel_in        = 3'd1;
        ex_bus.ex_alu_result_in    = addr;
        ex_bus.ex_load_size_in     = size;
        ex_bus.ex_load_unsigned_in = uns;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else pass_cnt++;
        check_cnt++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else pass_cnt++;
        check_cnt++; if (rd_data !== 32'h0) $display("FAIL reset_rd_out got %h want 0", rd_data); else pass_cnt++;
        check_cnt++; if (load_err !== 1'b0) $display("FAIL reset_load_err got %b want 0", load_err); else pass_cnt++;
        check_cnt++; if (ex_bus.ex_ready_out !== 1'b1 || stall !== 1'b0)
            $display("FAIL reset_ready got ready=%b stall=%b want 1/0", ex_bus.ex_ready_out, stall); else pass_cnt++;
    endtask

    task automatic test_alu();
        drive_op(5'd5, 3'd0, 1'b1, 32'h1234_5678);
        step();
        clear_ex();
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h1234_5678)
            $display("FAIL alu_write got we=%b rd=%0d d=%h want 1/5/12345678", wr_en, rd_addr, rd_data); else pass_cnt++;
        step();
        check_cnt++; if (wr_en !== 1'b0 || rd_data !== 32'h1234_5678)
            $display("FAIL alu_idle got we=%b d=%h want 0/12345678", wr_en, rd_data); else pass_cnt++;
    endtask

    task automatic test_byte_load();
        drive_load(5'd7, 32'h0000_0103, 2'd0, 1'b0);
        step();
        clear_ex();
        for (int i = 0; i < 3; i++) begin
            check_cnt++; if (stall !== 1'b1 || wr_en !== 1'b0)
                $display("FAIL byte_stall[%0d] got stall=%b we=%b want 1/0", i, stall, wr_en); else pass_cnt++;
            if (i < 2) step();
        end
        dm_rdata  = 32'h80FF_0000;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hFFFF_FF80)
            $display("FAIL byte_write got we=%b rd=%0d d=%h want 1/7/ffffff80", wr_en, rd_addr, rd_data); else pass_cnt++;
        check_cnt++; if (stall !== 1'b0) $display("FAIL byte_unstall got %b want 0", stall); else pass_cnt++;
        step();
        check_cnt++; if (wr_en !== 1'b0) $display("FAIL byte_after got we=%b want 0", wr_en); else pass_cnt++;
    endtask

    task automatic test_half_load();
        drive_load(5'd8, 32'h0000_2002, 2'd1, 1'b1);
        step();
        clear_ex();
        dm_rdata  = 32'hBEEF_1234;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd8 || rd_data !== 32'h0000_BEEF)
            $display("FAIL half_unsigned got we=%b rd=%0d d=%h want 1/8/0000beef", wr_en, rd_addr, rd_data); else pass_cnt++;
        drive_load(5'd9, 32'h0000_2003, 2'd1, 1'b0);
        step();
        clear_ex();
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'hFFFF_BEEF)
            $display("FAIL half_signed got we=%b rd=%0d d=%h want 1/9/ffffbeef", wr_en, rd_addr, rd_data); else pass_cnt++;
        drive_load(5'd10, 32'h0000_0001, 2'd3, 1'b0);
        step();
        clear_ex();
        dm_rdata  = 32'hDEAD_BEEF;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b1 || rd_data !== 32'hDEAD_BEEF)
            $display("FAIL size3_word got we=%b d=%h want 1/deadbeef", wr_en, rd_data); else pass_cnt++;
        drive_load(5'd11, 32'h0000_0001, 2'd0, 1'b1);
        step();
        clear_ex();
        dm_rdata  = 32'h0000_9C00;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b1 || rd_data !== 32'h0000_009C)
            $display("FAIL byte_unsigned got we=%b d=%h want 1/0000009c", wr_en, rd_data); else pass_cnt++;
    endtask

    task automatic test_rd0_guard();
        drive_op(5'd0, 3'd0, 1'b1, 32'hABCD_EF01);
        step();
        check_cnt++; if (wr_en !== 1'b0 || rd_data !== 32'hABCD_EF01)
            $display("FAIL rd0_guard got we=%b d=%h want 0/abcdef01", wr_en, rd_data); else pass_cnt++;
        drive_op(5'd1, 3'd3, 1'b1, 32'h0000_0104);
        step();
        clear_ex();
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd1 || rd_data !== 32'h0000_0104)
            $display("FAIL pc4_write got we=%b rd=%0d d=%h want 1/1/00000104", wr_en, rd_addr, rd_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        drive_op(5'd3, 3'd2, 1'b1, 32'hCAFE_F00D);
        step();
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'hCAFE_F00D)
            $display("FAIL b2b_csr got we=%b rd=%0d d=%h want 1/3/cafef00d", wr_en, rd_addr, rd_data); else pass_cnt++;
        drive_op(5'd4, 3'd4, 1'b1, 32'hABCD_E000);
        step();
        check_cnt++; if (wr_en !== 1'b1 || rd_addr !== 5'd4 || rd_data !== 32'hABCD_E000)
            $display("FAIL b2b_imm got we=%b rd=%0d d=%h want 1/4/abcde000", wr_en, rd_addr, rd_data); else pass_cnt++;
        drive_op(5'd6, 3'd5, 1'b1, 32'h1111_1111);
        step();
        check_cnt++; if (wr_en !== 1'b0 || rd_addr !== 5'd6 || stall !== 1'b0)
            $display("FAIL b2b_reserved got we=%b rd=%0d stall=%b want 0/6/0", wr_en, rd_addr, stall); else pass_cnt++;
        drive_op(5'd12, 3'd0, 1'b0, 32'h2222_2222);
        step();
        clear_ex();
        check_cnt++; if (wr_en !== 1'b0 || rd_addr !== 5'd12 || rd_data !== 32'h2222_2222)
            $display("FAIL b2b_no_we got we=%b rd=%0d d=%h want 0/12/22222222", wr_en, rd_addr, rd_data); else pass_cnt++;
        dm_rdata  = 32'h3333_3333;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b0 || stall !== 1'b0)
            $display("FAIL idle_rvalid got we=%b stall=%b want 0/0", wr_en, stall); else pass_cnt++;
    endtask

    task automatic test_timeout();
        drive_load(5'd13, 32'h0000_0000, 2'd2, 1'b0);
        step();
        clear_ex();
        for (int i = 0; i < 4; i++) begin
            check_cnt++; if (stall !== 1'b1 || wr_en !== 1'b0 || load_err !== 1'b0)
                $display("FAIL timeout_wait[%0d] got stall=%b we=%b err=%b want 1/0/0", i, stall, wr_en, load_err); else pass_cnt++;
            step();
        end
        check_cnt++; if (stall !== 1'b0 || wr_en !== 1'b0 || load_err !== 1'b1)
            $display("FAIL timeout_abort got stall=%b we=%b err=%b want 0/0/1", stall, wr_en, load_err); else pass_cnt++;
        dm_rdata  = 32'h4444_4444;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (wr_en !== 1'b0 || load_err !== 1'b1)
            $display("FAIL timeout_late_rvalid got we=%b err=%b want 0/1", wr_en, load_err); else pass_cnt++;
        step();
        check_cnt++; if (load_err !== 1'b1) $display("FAIL timeout_sticky got %b want 1", load_err); else pass_cnt++;
    endtask

    task automatic test_reset_mid_load();
        drive_load(5'd14, 32'h0000_0000, 2'd2, 1'b0);
        step();
        clear_ex();
        check_cnt++; if (stall !== 1'b1) $display("FAIL midrst_stall got %b want 1", stall); else pass_cnt++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cnt++; if (ex_bus.ex_ready_out !== 1'b1 || wr_en !== 1'b0 || load_err !== 1'b0)
            $display("FAIL midrst_state got ready=%b we=%b err=%b want 1/0/0", ex_bus.ex_ready_out, wr_en, load_err); else pass_cnt++;
        dm_rdata  = 32'h5A5A_5A5A;
        dm_rvalid = 1'b1;
        step();
        dm_rvalid = 1'b0;
        check_cnt++; if (ex_bus.ex_ready_out !== 1'b1 || wr_en !== 1'b0 || load_err !== 1'b0)
            $display("FAIL midrst_rvalid got ready=%b we=%b err=%b want 1/0/0", ex_bus.ex_ready_out, wr_en, load_err); else pass_cnt++;
        step();
        check_cnt++; if (wr_en !== 1'b0 || stall !== 1'b0)
            $display("FAIL midrst_after got we=%b stall=%b want 0/0", wr_en, stall); else pass_cnt++;
    endtask

    initial begin
        clear_ex();
        dm_rdata  = 32'h0;
        dm_rvalid = 1'b0;
        test_reset();
        test_alu();
        test_byte_load();
        test_half_load();
        test_rd0_guard();
        test_back_to_back();
        test_timeout();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
